fw_vector_loader: RTL

Fetch stage directly upstream of the dot-product multiplier. On a start command it streams one feature-matrix row and one weight-matrix column out of the feature and weight SRAMs, one element per cycle per memory. It assembles them into two FEATURE_COLS-wide vector registers and presents them with a valid/ack handshake. The valid signal drives the multiplier's enable_calc and read_feature_or_weight inputs. The row and column tags travel with the vectors so the result writer knows where the dot product belongs.

---
 rtl/gcn_pkg.sv | 20 ++
 rtl/vector_capture_reg.sv | 35 +++
 rtl/fw_vector_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/gcn_pkg.sv
// Shared definitions for the GCN datapath: the loader state encoding and the
// matrix geometry defaults used by the loader, the multiplier and the result
// writer.
package gcn_pkg;

   // Default matrix geometry
   localparam int GCN_FEATURE_COLS    = 96;
   localparam int GCN_WEIGHT_WIDTH    = 5;
   localparam int GCN_NUM_FEAT_ROWS   = 6;
   localparam int GCN_NUM_WEIGHT_COLS = 3;

   // Vector loader control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      VALID = 2'd3
   } loader_state_t;

endpackage : gcn_pkg

// File: rtl/vector_capture_reg.sv
// Indexed-write vector register: one element written per cycle at wr_idx.
// Every element clears on reset so a partially filled vector never survives.
module vector_capture_reg
   import gcn_pkg::*;
#(
   parameter  int LEN   = GCN_FEATURE_COLS,
   parameter  int WIDTH = GCN_WEIGHT_WIDTH,
   localparam int IDX_W = $clog2(LEN)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [IDX_W-1:0]           wr_idx,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [LEN-1:0][WIDTH-1:0]  vec
);

   logic [LEN-1:0][WIDTH-1:0] vec_q;

   // Write the addressed element; indices at or beyond LEN are ignored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vec_q <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < LEN; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               vec_q[i] <= wr_data;
            end
         end
      end
   end

   assign vec = vec_q;

endmodule : vector_capture_reg

// File: rtl/fw_vector_loader.sv
// Feature/weight vector loader. A start command streams one feature row and one
// weight column out of the two SRAMs (one element per cycle each), assembles
// them into vector registers and presents them with a valid/ack handshake,
// together with the row/column tags that identify the dot product.
module fw_vector_loader
   import gcn_pkg::*;
#(
   parameter  int FEATURE_COLS    = GCN_FEATURE_COLS,
   parameter  int WEIGHT_WIDTH    = GCN_WEIGHT_WIDTH,
   parameter  int NUM_FEAT_ROWS   = GCN_NUM_FEAT_ROWS,
   parameter  int NUM_WEIGHT_COLS = GCN_NUM_WEIGHT_COLS,
   localparam int FADDR_W         = $clog2(NUM_FEAT_ROWS*FEATURE_COLS),
   localparam int WADDR_W         = $clog2(NUM_WEIGHT_COLS*FEATURE_COLS),
   localparam int RIDX_W          = $clog2(NUM_FEAT_ROWS),
   localparam int CIDX_W          = $clog2(NUM_WEIGHT_COLS)
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        start,
   input  logic [RIDX_W-1:0]                           row_idx,
   input  logic [CIDX_W-1:0]                           col_idx,
   output logic                                        busy,
   output logic                                        idx_err,
   output logic                                        f_rd_en,
   output logic [FADDR_W-1:0]                          f_addr,
   input  logic [WEIGHT_WIDTH-1:0]                     f_rdata,
   output logic                                        w_rd_en,
   output logic [WADDR_W-1:0]                          w_addr,
   input  logic [WEIGHT_WIDTH-1:0]                     w_rdata,
   output logic                                        vec_valid,
   input  logic                                        vec_ack,
   output logic [FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0]   feature_row,
   output logic [FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0]   weight_col,
   output logic [RIDX_W-1:0]                           out_row_idx,
   output logic [CIDX_W-1:0]                           out_col_idx
);

   localparam int             K_W    = $clog2(FEATURE_COLS);
   localparam logic [K_W-1:0] K_LAST = K_W'(FEATURE_COLS - 1);

   loader_state_t      state_q, state_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [RIDX_W-1:0]  row_q, row_d;
   logic [CIDX_W-1:0]  col_q, col_d;
   logic               idx_err_q, idx_err_d;
   logic               busy_q;
   logic               vec_valid_q;
   logic               cap_en_q;
   logic [K_W-1:0]     cap_idx_q;
   logic               start_bad;

   // Reject requests that name a row or column outside the stored matrices
   always_comb begin
      start_bad = (32'(row_idx) >= 32'(NUM_FEAT_ROWS)) ||
                  (32'(col_idx) >= 32'(NUM_WEIGHT_COLS));
   end

   // Control FSM next state, element counter and tag latching
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      row_d     = row_q;
      col_d     = col_q;
      idx_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (start_bad) begin
                  idx_err_d = 1'b1;
               end else begin
                  row_d   = row_idx;
                  col_d   = col_idx;
                  k_d     = '0;
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            if (k_q == K_LAST) begin
               k_d     = '0;
               state_d = DRAIN;
            end else begin
               k_d = k_q + K_W'(1);
            end
         end
         DRAIN: begin
            // last read data arrives this cycle; vectors complete at the next edge
            state_d = VALID;
         end
         VALID: begin
            // an ack wins over a simultaneous start, which is simply dropped
            if (vec_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and tag registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   // Registered status outputs, derived from the next state so they line up
   // with the state register rather than lagging it by a cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q      <= 1'b0;
         vec_valid_q <= 1'b0;
         idx_err_q   <= 1'b0;
      end else begin
         busy_q      <= (state_d != IDLE);
         vec_valid_q <= (state_d == VALID);
         idx_err_q   <= idx_err_d;
      end
   end

   // Capture pipeline: the SRAMs answer one cycle after the read, so the
   // element index is delayed by one cycle alongside a write enable
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_en_q  <= 1'b0;
         cap_idx_q <= '0;
      end else begin
         cap_en_q  <= (state_q == FETCH);
         cap_idx_q <= k_q;
      end
   end

   // SRAM read ports decode straight from state and counter; addresses are
   // zero outside FETCH so an idle loader presents a quiet bus
   always_comb begin
      f_rd_en = 1'b0;
      w_rd_en = 1'b0;
      f_addr  = '0;
      w_addr  = '0;
      if (state_q == FETCH) begin
         f_rd_en = 1'b1;
         w_rd_en = 1'b1;
         f_addr  = FADDR_W'(row_q) * FADDR_W'(FEATURE_COLS) + FADDR_W'(k_q);
         w_addr  = WADDR_W'(col_q) * WADDR_W'(FEATURE_COLS) + WADDR_W'(k_q);
      end
   end

   vector_capture_reg #(
      .LEN   (FEATURE_COLS),
      .WIDTH (WEIGHT_WIDTH)
   ) u_feat_cap (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (cap_en_q),
      .wr_idx  (cap_idx_q),
      .wr_data (f_rdata),
      .vec     (feature_row)
   );

   vector_capture_reg #(
      .LEN   (FEATURE_COLS),
      .WIDTH (WEIGHT_WIDTH)
   ) u_wgt_cap (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (cap_en_q),
      .wr_idx  (cap_idx_q),
      .wr_data (w_rdata),
      .vec     (weight_col)
   );

   assign busy        = busy_q;
   assign idx_err     = idx_err_q;
   assign vec_valid   = vec_valid_q;
   assign out_row_idx = row_q;
   assign out_col_idx = col_q;

endmodule : fw_vector_loader
